// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath select codes, instruction classes and the registered control bundle.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_OR   = 2'd2;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;

    localparam logic [1:0] RS_ALU   = 2'd0;
    localparam logic [1:0] RS_MEM   = 2'd1;
    localparam logic [1:0] RS_PC    = 2'd2;

    // One-hot instruction class bit positions; an all-zero class means illegal.
    localparam int NUM_CLS = 11;
    localparam int CL_NOP  = 0;
    localparam int CL_ADDU = 1;
    localparam int CL_SUBU = 2;
    localparam int CL_JR   = 3;
    localparam int CL_ORI  = 4;
    localparam int CL_LW   = 5;
    localparam int CL_SW   = 6;
    localparam int CL_BEQ  = 7;
    localparam int CL_LUI  = 8;
    localparam int CL_J    = 9;
    localparam int CL_JAL  = 10;

    typedef logic [NUM_CLS-1:0] cls_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] reg_src;
        logic [1:0] ext_op;
        logic       alu_b_sel;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic [1:0] cls_ext_op(cls_t c);
        logic [1:0] ext;
        if (c[CL_LUI]) begin
            ext = EXT_LUI;
        end else if (c[CL_LW] | c[CL_SW] | c[CL_BEQ]) begin
            ext = EXT_SIGN;
        end else begin
            ext = EXT_ZERO;
        end
        return ext;
    endfunction

    function automatic logic [1:0] cls_alu_op(cls_t c);
        logic [1:0] op;
        if (c[CL_SUBU] | c[CL_BEQ]) begin
            op = ALU_SUB;
        end else if (c[CL_ORI]) begin
            op = ALU_OR;
        end else begin
            op = ALU_ADD;
        end
        return op;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Shared instruction/data memory handshake between the controller and memory.
interface mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: IR word to one-hot class plus illegal flag.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output cls_t        cls,
    output logic        illegal
);

    logic [5:0] w_op;
    logic [5:0] w_fn;

    assign w_op = instr[31:26];
    assign w_fn = instr[5:0];

    // Class lookup; R-type funct 0 is only accepted as the all-zero nop word.
    always_comb begin
        cls = '0;
        case (w_op)
            OP_RTYPE: begin
                if (instr == 32'h0000_0000) begin
                    cls[CL_NOP] = 1'b1;
                end else begin
                    case (w_fn)
                        FN_ADDU: cls[CL_ADDU] = 1'b1;
                        FN_SUBU: cls[CL_SUBU] = 1'b1;
                        FN_JR:   cls[CL_JR]   = 1'b1;
                        default: cls = '0;
                    endcase
                end
            end
            OP_J:    cls[CL_J]   = 1'b1;
            OP_JAL:  cls[CL_JAL] = 1'b1;
            OP_BEQ:  cls[CL_BEQ] = 1'b1;
            OP_ORI:  cls[CL_ORI] = 1'b1;
            OP_LUI:  cls[CL_LUI] = 1'b1;
            OP_LW:   cls[CL_LW]  = 1'b1;
            OP_SW:   cls[CL_SW]  = 1'b1;
            default: cls = '0;
        endcase
    end

    assign illegal = (cls == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath selects from registered state, and counts retired instructions.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        zero,
    mc_ctrl_if.master   mem,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  reg_src,
    output logic [1:0]  ext_op,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic [31:0] retired,
    output logic [2:0]  state
);

    cls_t        w_cls;
    logic        w_dec_illegal;
    state_e      r_state;
    state_e      w_next_state;
    ctrl_t       r_ctrl;
    logic [31:0] r_retired;
    logic        w_fetch_done;
    logic        w_mem_done;
    logic        w_beq_take;
    logic        w_retire;
    logic        w_is_jump;

    mc_ctrl_decode u_decode (
        .instr   (instr),
        .cls     (w_cls),
        .illegal (w_dec_illegal)
    );

    // Control word for the state being entered; class is stable once IR is loaded.
    function automatic ctrl_t ctrl_for(state_e st, cls_t c);
        ctrl_t ctl;
        ctl = '0;
        case (st)
            ST_FETCH: ctl.mem_req = 1'b1;
            ST_DECODE: ctl = '0;
            ST_EXEC: begin
                ctl.ext_op    = cls_ext_op(c);
                ctl.alu_op    = cls_alu_op(c);
                ctl.alu_b_sel = c[CL_ORI] | c[CL_LUI] | c[CL_LW] | c[CL_SW];
                ctl.pc_we     = c[CL_J] | c[CL_JR] | c[CL_JAL];
                if (c[CL_BEQ]) begin
                    ctl.pc_src = PC_BRANCH;
                end else if (c[CL_J] | c[CL_JAL]) begin
                    ctl.pc_src = PC_JUMP;
                end else if (c[CL_JR]) begin
                    ctl.pc_src = PC_REG;
                end else begin
                    ctl.pc_src = PC_SEQ;
                end
                if (c[CL_JAL]) begin
                    ctl.reg_we  = 1'b1;
                    ctl.reg_dst = RD_RA;
                    ctl.reg_src = RS_PC;
                end else begin
                    ctl.reg_we  = 1'b0;
                end
            end
            ST_MEM: begin
                ctl.ext_op       = cls_ext_op(c);
                ctl.alu_op       = cls_alu_op(c);
                ctl.mem_req      = 1'b1;
                ctl.mem_addr_sel = 1'b1;
                ctl.mem_we       = c[CL_SW];
            end
            ST_WB: begin
                ctl.ext_op  = cls_ext_op(c);
                ctl.alu_op  = cls_alu_op(c);
                ctl.reg_we  = 1'b1;
                ctl.reg_dst = (c[CL_ADDU] | c[CL_SUBU]) ? RD_RD : RD_RT;
                ctl.reg_src = c[CL_LW] ? RS_MEM : RS_ALU;
            end
            default: ctl = '0;
        endcase
        return ctl;
    endfunction

    // Handshakes only count while our own request is actually raised.
    assign w_fetch_done = (r_state == ST_FETCH) & r_ctrl.mem_req & mem.mem_ready;
    assign w_mem_done   = (r_state == ST_MEM) & r_ctrl.mem_req & mem.mem_ready;
    assign w_beq_take   = (r_state == ST_EXEC) & w_cls[CL_BEQ] & zero;
    assign w_is_jump    = w_cls[CL_BEQ] | w_cls[CL_J] | w_cls[CL_JR] | w_cls[CL_JAL];

    // Next-state and retire decision.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_fetch_done) begin
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (w_cls[CL_NOP]) begin
                    w_next_state = ST_FETCH;
                    w_retire     = 1'b1;
                end else if (w_dec_illegal) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_cls[CL_LW] | w_cls[CL_SW]) begin
                    w_next_state = ST_MEM;
                end else if (w_is_jump) begin
                    w_next_state = ST_FETCH;
                    w_retire     = 1'b1;
                end else begin
                    w_next_state = ST_WB;
                end
            end
            ST_MEM: begin
                if (w_mem_done && w_cls[CL_SW]) begin
                    w_next_state = ST_FETCH;
                    w_retire     = 1'b1;
                end else if (w_mem_done) begin
                    w_next_state = ST_WB;
                end else begin
                    w_next_state = ST_MEM;
                end
            end
            ST_WB: begin
                w_next_state = ST_FETCH;
                w_retire     = 1'b1;
            end
            default: begin
                w_next_state = ST_FETCH;
                w_retire     = 1'b0;
            end
        endcase
    end

    // State, registered control word and retired counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_FETCH;
            r_ctrl    <= '0;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= ctrl_for(w_next_state, w_cls);
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end else begin
                r_retired <= r_retired;
            end
        end
    end

    assign mem.mem_req      = r_ctrl.mem_req;
    assign mem.mem_we       = r_ctrl.mem_we;
    assign mem.mem_addr_sel = r_ctrl.mem_addr_sel;
    assign ir_we            = w_fetch_done;
    assign pc_we            = r_ctrl.pc_we | w_fetch_done | w_beq_take;
    assign pc_src           = r_ctrl.pc_src;
    assign reg_we           = r_ctrl.reg_we;
    assign reg_dst          = r_ctrl.reg_dst;
    assign reg_src          = r_ctrl.reg_src;
    assign ext_op           = r_ctrl.ext_op;
    assign alu_b_sel        = r_ctrl.alu_b_sel;
    assign alu_op           = r_ctrl.alu_op;
    assign illegal          = (r_state == ST_DECODE) & w_dec_illegal;
    assign retired          = r_retired;
    assign state            = r_state;

endmodule
